// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared FSM encoding and width helper for the PE operand fetch
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        FETCH     = 2'd2,
        ADVANCE   = 2'd3
    } pe_state_t;

    // Ceiling log2, never below 1 so it is always usable as a vector width.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/if_circ_spad.sv
// rtl/if_circ_spad.sv - IF sample circular scratchpad with occupancy count
module if_circ_spad
    import pe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int STRIDE = 1,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic [AW-1:0]    rd_offset,
    output logic [WIDTH-1:0] rd_data,
    input  logic             advance,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_addr;
    logic             wr_accept;

    assign wr_ready  = (count < CW'(DEPTH));
    assign wr_accept = wr_valid && wr_ready;
    // Depth is a power of two, so the AW-bit sum wraps modulo depth.
    assign rd_addr   = rd_ptr + rd_offset;
    assign rd_data   = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (advance) begin
                rd_ptr <= rd_ptr + AW'(STRIDE);
            end
            count <= count + CW'(wr_accept) - (advance ? CW'(STRIDE) : CW'(0));
        end
    end

endmodule

// File: rtl/pe_operand_fetch.sv
// rtl/pe_operand_fetch.sv - windowed IF/filter operand sequencer feeding a MAC
module pe_operand_fetch
    import pe_pkg::*;
#(
    parameter int IF_CELL_SIZE     = 8,
    parameter int FILTER_CELL_SIZE = 8,
    parameter int FILTER_SIZE      = 4,
    parameter int IF_SPAD_DEPTH    = 16,
    parameter int STRIDE           = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              if_wr_valid,
    input  logic [IF_CELL_SIZE-1:0]           if_wr_data,
    output logic                              if_wr_ready,
    input  logic                              filt_wr_en,
    input  logic [clog2(FILTER_SIZE)-1:0]     filt_wr_addr,
    input  logic [FILTER_CELL_SIZE-1:0]       filt_wr_data,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              pipe_stall,
    output logic [IF_CELL_SIZE-1:0]           if_out,
    output logic [FILTER_CELL_SIZE-1:0]       filter_out,
    output logic                              ld_mult,
    output logic                              ld_add,
    output logic                              par_done,
    output logic                              busy
);

    localparam int TW = clog2(FILTER_SIZE);
    localparam int AW = clog2(IF_SPAD_DEPTH);
    localparam int CW = AW + 1;

    pe_state_t                   state, next_state;
    logic [TW-1:0]               tap;
    logic                        stop_q;
    logic [CW-1:0]               count;
    logic [IF_CELL_SIZE-1:0]     spad_rd_data;
    logic [FILTER_CELL_SIZE-1:0] filt_mem [FILTER_SIZE];
    logic                        issue;
    logic                        last_tap;
    logic                        advance;

    assign issue    = (state == FETCH) && !pipe_stall;
    assign last_tap = (tap == TW'(FILTER_SIZE - 1));
    assign advance  = (state == ADVANCE) && !pipe_stall;

    if_circ_spad #(
        .WIDTH  (IF_CELL_SIZE),
        .DEPTH  (IF_SPAD_DEPTH),
        .STRIDE (STRIDE)
    ) u_spad (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (if_wr_valid),
        .wr_data   (if_wr_data),
        .wr_ready  (if_wr_ready),
        .rd_offset (AW'(tap)),
        .rd_data   (spad_rd_data),
        .advance   (advance),
        .count     (count)
    );

    // Filter taps survive reset; they are only rewritten while idle.
    always_ff @(posedge clk) begin
        if (filt_wr_en && !busy) begin
            filt_mem[filt_wr_addr] <= filt_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!pipe_stall) begin
            case (state)
                IDLE:      if (start) next_state = WAIT_DATA;
                WAIT_DATA: if (count >= CW'(FILTER_SIZE)) next_state = FETCH;
                FETCH:     if (last_tap) next_state = ADVANCE;
                ADVANCE:   next_state = (stop_q || stop) ? IDLE : WAIT_DATA;
                default:   next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap    <= '0;
            stop_q <= 1'b0;
        end else begin
            if (issue) begin
                tap <= last_tap ? '0 : tap + 1'b1;
            end
            if (state == IDLE || advance) begin
                stop_q <= 1'b0;
            end else if (stop) begin
                stop_q <= 1'b1;
            end
        end
    end

    // Operand register stage; a stall freezes the whole stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_out     <= '0;
            filter_out <= '0;
            ld_mult    <= 1'b0;
            ld_add     <= 1'b0;
            par_done   <= 1'b0;
        end else if (!pipe_stall) begin
            ld_mult  <= issue;
            ld_add   <= ld_mult;
            par_done <= issue && last_tap;
            if (issue) begin
                if_out     <= spad_rd_data;
                filter_out <= filt_mem[tap];
            end
        end
    end

endmodule

// File: tb/tb_pe_operand_fetch.sv
// tb/tb_pe_operand_fetch.sv - directed self-checking bench for pe_operand_fetch
module tb_pe_operand_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       if_wr_valid = 1'b0;
    logic [7:0] if_wr_data = 8'd0;
    logic       if_wr_ready;
    logic       filt_wr_en = 1'b0;
    logic [1:0] filt_wr_addr = 2'd0;
    logic [7:0] filt_wr_data = 8'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pipe_stall = 1'b0;
    logic [7:0] if_out;
    logic [7:0] filter_out;
    logic       ld_mult;
    logic       ld_add;
    logic       par_done;
    logic       busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    pe_operand_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .if_wr_valid  (if_wr_valid),
        .if_wr_data   (if_wr_data),
        .if_wr_ready  (if_wr_ready),
        .filt_wr_en   (filt_wr_en),
        .filt_wr_addr (filt_wr_addr),
        .filt_wr_data (filt_wr_data),
        .start        (start),
        .stop         (stop),
        .pipe_stall   (pipe_stall),
        .if_out       (if_out),
        .filter_out   (filter_out),
        .ld_mult      (ld_mult),
        .ld_add       (ld_add),
        .par_done     (par_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr_if(input logic [7:0] value);
        if_wr_valid = 1'b1;
        if_wr_data  = value;
        step();
        if_wr_valid = 1'b0;
    endtask

    task automatic wait_ld(input string tag);
        for (int i = 0; i < 12; i++) begin
            if (ld_mult === 1'b1) break;
            step();
        end
        check(tag, ld_mult, 1);
    endtask

    // Checks one full unstalled window of IF values base..base+3 against taps 1..4.
    // A non-negative wr_val is written on the edge that performs ADVANCE.
    task automatic window(input string tag, input int base, input int wr_val);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_if%0d", tag, k), if_out, base + k);
            check($sformatf("%s_flt%0d", tag, k), filter_out, k + 1);
            check($sformatf("%s_pd%0d", tag, k), par_done, (k == 3) ? 1 : 0);
            check($sformatf("%s_add%0d", tag, k), ld_add, (k > 0) ? 1 : 0);
            if (k == 3 && wr_val >= 0) begin
                if_wr_valid = 1'b1;
                if_wr_data  = 8'(wr_val);
            end
            step();
            if_wr_valid = 1'b0;
        end
        check($sformatf("%s_ldm_end", tag), ld_mult, 0);
        check($sformatf("%s_add_end", tag), ld_add, 1);
    endtask

    initial begin
        logic pd_seen;

        step();
        step();
        check("rst_ldm", ld_mult, 0);
        check("rst_if", if_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", if_wr_ready, 1);
        check("rst_pd", par_done, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            filt_wr_en   = 1'b1;
            filt_wr_addr = 2'(i);
            filt_wr_data = 8'(i + 1);
            step();
        end
        filt_wr_en = 1'b0;

        // Basic window
        for (int v = 1; v <= 4; v++) wr_if(8'(v));
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", busy, 1);
        wait_ld("w1_start");
        window("w1", 1, -1);

        // Sliding windows with stride 1, then a data starve
        wr_if(8'd5);
        wr_if(8'd6);
        wait_ld("w2_start");
        window("w2", 2, -1);
        wait_ld("w3_start");
        window("w3", 3, -1);
        filt_wr_en   = 1'b1;
        filt_wr_addr = 2'd0;
        filt_wr_data = 8'd9;
        step();
        filt_wr_en = 1'b0;
        repeat (7) step();
        check("starve_ldm", ld_mult, 0);
        check("starve_busy", busy, 1);
        check("starve_count", dut.u_spad.count, 3);

        // Stall in the middle of the window
        wr_if(8'd7);
        wait_ld("w4_start");
        check("st_if0", if_out, 4);
        check("st_flt0_locked", filter_out, 1);
        step();
        check("st_if1", if_out, 5);
        step();
        check("st_if2", if_out, 6);
        pipe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("st_hold_if%0d", i), if_out, 6);
            check($sformatf("st_hold_flt%0d", i), filter_out, 3);
            check($sformatf("st_hold_ldm%0d", i), ld_mult, 1);
            check($sformatf("st_hold_add%0d", i), ld_add, 1);
            check($sformatf("st_hold_pd%0d", i), par_done, 0);
        end
        pipe_stall = 1'b0;
        step();
        check("st_if3", if_out, 7);
        check("st_flt3", filter_out, 4);
        check("st_pd3", par_done, 1);
        step();
        check("st_ldm_end", ld_mult, 0);
        check("st_pd_end", par_done, 0);

        // Full scratchpad, dropped write, stop handling
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int v = 10; v < 26; v++) wr_if(8'(v));
        check("full_ready", if_wr_ready, 0);
        check("full_count", dut.u_spad.count, 16);
        wr_if(8'd99);
        check("drop_count", dut.u_spad.count, 16);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_ld("f1_start");
        window("f1", 10, -1);
        check("adv_count", dut.u_spad.count, 15);
        check("adv_ready", if_wr_ready, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_ld("f2_start");
        window("f2", 11, -1);
        check("stop_busy", busy, 0);
        check("stop_count", dut.u_spad.count, 14);

        // Write coinciding with ADVANCE, then reset mid-window
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int v = 1; v <= 4; v++) wr_if(8'(v));
        start = 1'b1;
        step();
        start = 1'b0;
        wait_ld("c1_start");
        window("c1", 1, 5);
        check("coincide_count", dut.u_spad.count, 4);
        wait_ld("c2_start");
        check("c2_if0", if_out, 2);
        step();
        step();
        check("c2_if2", if_out, 4);
        rst = 1'b1;
        step();
        check("mid_rst_ldm", ld_mult, 0);
        check("mid_rst_add", ld_add, 0);
        check("mid_rst_pd", par_done, 0);
        check("mid_rst_if", if_out, 0);
        check("mid_rst_flt", filter_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", if_wr_ready, 1);
        rst = 1'b0;
        pd_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            pd_seen = pd_seen | par_done | ld_mult;
        end
        check("post_rst_quiet", pd_seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
